// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and constants for the mem_arbiter memory-bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    SEL_WR = 2'd0,
    SEL_DR = 2'd1,
    SEL_IR = 2'd2
  } arb_sel_e;

  localparam logic [31:0] C_ERR_DATA_DEF = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/mem_arb_slot.sv
// ============================================================================
// Module   : mem_arb_slot
// Brief    : Request capture register with a full flag, capture enable and clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_slot #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cap_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic         full_o,
  output logic [W-1:0] q_o
);

  logic         full_q;
  logic [W-1:0] data_q;

  // Capture only ever happens with the slot empty, so ordering against clear is moot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      if (clr_i) begin
        full_q <= 1'b0;
      end
      if (cap_i) begin
        full_q <= 1'b1;
        data_q <= d_i;
      end
    end
  end

  assign full_o = full_q;
  assign q_o    = data_q;

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one memory bus between instruction-read and data read/write
//            channels; optional transaction timeout under MEM_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter logic [31:0] ERR_DATA    = C_ERR_DATA_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INST_RDEN,
  input  logic [31:0] INST_RIADDR,
  output logic [31:0] INST_ROADDR,
  output logic        INST_RVALID,
  output logic [31:0] INST_RDATA,
  input  logic        DATA_RDEN,
  input  logic [31:0] DATA_RIADDR,
  output logic [31:0] DATA_ROADDR,
  output logic        DATA_RVALID,
  output logic [31:0] DATA_RDATA,
  input  logic        DATA_WREN,
  input  logic [3:0]  DATA_WSTRB,
  input  logic [31:0] DATA_WADDR,
  input  logic [31:0] DATA_WDATA,
  output logic        MEM_WAIT,
  output logic        BUS_REQ,
  output logic        BUS_WE,
  output logic [31:0] BUS_ADDR,
  output logic [3:0]  BUS_WSTRB,
  output logic [31:0] BUS_WDATA,
  input  logic        BUS_GNT,
  input  logic        BUS_RVALID,
  input  logic [31:0] BUS_RDATA,
  output logic        BUS_TIMEOUT
);

  arb_state_e state_q, state_d;
  arb_sel_e   sel_q, sel_d;

  logic        w_cap;
  logic        w_wr_full, w_dr_full, w_ir_full;
  logic        w_wr_pend, w_dr_pend, w_ir_pend;
  logic [67:0] w_wr_q;
  logic [31:0] w_dr_q, w_ir_q;
  logic        w_clr_wr, w_clr_dr, w_clr_ir;
  logic        w_done, w_load, w_expired, w_timeout;
  logic [31:0] w_load_data;

  logic        inst_rvalid_q, data_rvalid_q;
  logic [31:0] inst_rdata_q, inst_roaddr_q, data_rdata_q, data_roaddr_q;

  assign MEM_WAIT = w_wr_full | w_dr_full | w_ir_full;
  assign w_cap    = ~MEM_WAIT;

  mem_arb_slot #(.W(68)) u_wr_slot (
    .clk_i  (CLK),
    .rst_i  (RST),
    .cap_i  (w_cap & DATA_WREN),
    .clr_i  (w_clr_wr),
    .d_i    ({DATA_WADDR, DATA_WDATA, DATA_WSTRB}),
    .full_o (w_wr_full),
    .q_o    (w_wr_q)
  );

  mem_arb_slot #(.W(32)) u_dr_slot (
    .clk_i  (CLK),
    .rst_i  (RST),
    .cap_i  (w_cap & DATA_RDEN),
    .clr_i  (w_clr_dr),
    .d_i    (DATA_RIADDR),
    .full_o (w_dr_full),
    .q_o    (w_dr_q)
  );

  mem_arb_slot #(.W(32)) u_ir_slot (
    .clk_i  (CLK),
    .rst_i  (RST),
    .cap_i  (w_cap & INST_RDEN),
    .clr_i  (w_clr_ir),
    .d_i    (INST_RIADDR),
    .full_o (w_ir_full),
    .q_o    (w_ir_q)
  );

  // Requests being captured this edge count as pending so issue starts one cycle later.
  assign w_wr_pend = w_wr_full | (w_cap & DATA_WREN);
  assign w_dr_pend = w_dr_full | (w_cap & DATA_RDEN);
  assign w_ir_pend = w_ir_full | (w_cap & INST_RDEN);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] C_TO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] cnt_q, cnt_d;

  // Held at zero while idle, which is equivalent to clearing on entry to ISSUE.
  assign cnt_d     = (state_q == IDLE) ? 16'd0 : cnt_q + 16'd1;
  assign w_expired = (state_q != IDLE) && (cnt_q == C_TO_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign w_expired          = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    w_done      = 1'b0;
    w_load      = 1'b0;
    w_load_data = BUS_RDATA;
    w_timeout   = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_wr_pend | w_dr_pend | w_ir_pend) begin
          state_d = ISSUE;
          if (w_wr_pend)      sel_d = SEL_WR;
          else if (w_dr_pend) sel_d = SEL_DR;
          else                sel_d = SEL_IR;
        end
      end
      ISSUE: begin
        if (w_expired) begin
          w_timeout   = 1'b1;
          w_done      = 1'b1;
          w_load      = (sel_q != SEL_WR);
          w_load_data = ERR_DATA;
          state_d     = IDLE;
        end else if (BUS_GNT) begin
          if (sel_q == SEL_WR) begin
            w_done  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (BUS_RVALID) begin
          w_done  = 1'b1;
          w_load  = 1'b1;
          state_d = IDLE;
        end else if (w_expired) begin
          w_timeout   = 1'b1;
          w_done      = 1'b1;
          w_load      = 1'b1;
          w_load_data = ERR_DATA;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign w_clr_wr    = w_done && (sel_q == SEL_WR);
  assign w_clr_dr    = w_done && (sel_q == SEL_DR);
  assign w_clr_ir    = w_done && (sel_q == SEL_IR);
  assign BUS_TIMEOUT = w_timeout;

  always_comb begin
    BUS_REQ   = (state_q == ISSUE);
    BUS_WE    = 1'b0;
    BUS_ADDR  = 32'd0;
    BUS_WSTRB = 4'd0;
    BUS_WDATA = 32'd0;
    if (state_q == ISSUE) begin
      case (sel_q)
        SEL_WR: begin
          BUS_WE                           = 1'b1;
          {BUS_ADDR, BUS_WDATA, BUS_WSTRB} = w_wr_q;
        end
        SEL_DR:  BUS_ADDR = w_dr_q;
        default: BUS_ADDR = w_ir_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      sel_q         <= SEL_WR;
      inst_rvalid_q <= 1'b0;
      data_rvalid_q <= 1'b0;
      inst_rdata_q  <= 32'd0;
      inst_roaddr_q <= 32'd0;
      data_rdata_q  <= 32'd0;
      data_roaddr_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      inst_rvalid_q <= w_load && (sel_q == SEL_IR);
      data_rvalid_q <= w_load && (sel_q == SEL_DR);
      if (w_load && (sel_q == SEL_IR)) begin
        inst_rdata_q  <= w_load_data;
        inst_roaddr_q <= w_ir_q;
      end
      if (w_load && (sel_q == SEL_DR)) begin
        data_rdata_q  <= w_load_data;
        data_roaddr_q <= w_dr_q;
      end
    end
  end

  assign INST_RVALID = inst_rvalid_q;
  assign INST_RDATA  = inst_rdata_q;
  assign INST_ROADDR = inst_roaddr_q;
  assign DATA_RVALID = data_rvalid_q;
  assign DATA_RDATA  = data_rdata_q;
  assign DATA_ROADDR = data_roaddr_q;

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported memory bus between the core's instruction-read channel and its data read/write channel.
- Sits between the core's physical memory ports (downstream of the MMU) and the memory/interconnect.
- Captures requests into slots and drains them one bus transaction at a time.
- Drives MEM_WAIT back to the core while any slot is occupied.

Parameters:
TIMEOUT_CYC, 1024, cycles allowed from bus issue to completion before forced abort (used only with MEM_ARB_TIMEOUT_EN)
ERR_DATA, 32'h0000_0000, read data returned on a timed-out read

Ports:
CLK  in  1  clock
RST  in  1  asynchronous reset, active-high
INST_RDEN  in  1  instruction read request
INST_RIADDR  in  32  instruction read address
INST_ROADDR  out  32  address echoed with returned instruction
INST_RVALID  out  1  instruction data valid, 1-cycle pulse
INST_RDATA  out  32  instruction data
DATA_RDEN  in  1  data read request
DATA_RIADDR  in  32  data read address
DATA_ROADDR  out  32  address echoed with returned data
DATA_RVALID  out  1  data valid, 1-cycle pulse
DATA_RDATA  out  32  read data
DATA_WREN  in  1  data write request
DATA_WSTRB  in  4  byte strobes
DATA_WADDR  in  32  write address
DATA_WDATA  in  32  write data
MEM_WAIT  out  1  stall to core; high while any slot is occupied (combinational from slot flags)
BUS_REQ  out  1  bus request, held until BUS_GNT
BUS_WE  out  1  1 = write, 0 = read
BUS_ADDR  out  32  bus address
BUS_WSTRB  out  4  bus strobes (0 on reads)
BUS_WDATA  out  32  bus write data
BUS_GNT  in  1  bus accepted the request this cycle
BUS_RVALID  in  1  read response valid
BUS_RDATA  in  32  read response data
BUS_TIMEOUT  out  1  1-cycle pulse when a transaction is aborted

Behaviour:
- Reset: every output 0, all slots empty, FSM = IDLE. Assertion mid-transaction drops BUS_REQ immediately and discards all slots; a BUS_RVALID arriving later in IDLE is ignored.
- Slots: WR (addr/data/strb), DR (addr), IR (addr). On any rising edge where MEM_WAIT == 0, each slot latches its request if the matching enable is high. While MEM_WAIT == 1 all request inputs are ignored; no re-capture of held requests.
- Grant order: WR > DR > IR.
- FSM states:
  - IDLE: when any slot is full, select the highest-priority slot, then go to ISSUE.
  - ISSUE: BUS_REQ = 1 with the selected slot's fields. On BUS_GNT: a write clears WR (posted) and returns to IDLE; a read goes to RESP.
  - RESP: on BUS_RVALID, register data and echoed address to the owner's *_RDATA/*_ROADDR, pulse *_RVALID on the next cycle, clear the slot, return to IDLE.
- Outputs hold last values between pulses.
- Minimum read latency: RDEN at c0 → BUS_REQ+GNT at c1 → BUS_RVALID at c2 → *_RVALID at c3, with MEM_WAIT low at c3.
- Zero requests: MEM_WAIT stays 0 and the bus stays idle.
- RDEN and WREN together with RDEN for both channels: three transactions in order WR, DR, IR; MEM_WAIT stays high until the last *_RVALID.
- BUS_GNT or BUS_RVALID in an unexpected state is ignored.

Optional Feature:
MEM_ARB_TIMEOUT_EN:
- Defined:
  - A 16-bit counter clears on entry to ISSUE and counts in ISSUE and RESP.
  - At count == TIMEOUT_CYC-1, the transaction is aborted and BUS_TIMEOUT pulses.
  - A read completes normally except *_RDATA = ERR_DATA; a write is dropped; in both cases the slot clears and FSM → IDLE.
- Undefined: no counter, BUS_TIMEOUT tied 0, and the FSM waits indefinitely.

Decomposition:
- Package mem_arb_pkg: FSM state enum (IDLE, ISSUE, RESP), slot-select enum (SEL_WR, SEL_DR, SEL_IR), ERR_DATA default constant.
- One sub-module, mem_arb_slot: a parameterised-width capture register with full flag, capture enable and clear; instantiated for IR and DR, and widened for WR.

Test Plan:
- Inst-only read: INST_RDEN=1, addr 0x100; GNT same cycle; RVALID next cycle with data 0xDEADBEEF → INST_RVALID pulse at c3, ROADDR=0x100, RDATA=0xDEADBEEF, MEM_WAIT high c1-c2.
- Simultaneous WR(0x200, 0x11223344, strb 4'hF) + DR(0x204) + IR(0x000) → bus sees write 0x200, then read 0x204, then read 0x000; DATA_RVALID precedes INST_RVALID.
- GNT held low 5 cycles → BUS_REQ and fields stable all 5 cycles; no capture of changed inputs while MEM_WAIT=1.
- RST asserted during RESP, then a late BUS_RVALID → no *_RVALID pulse, BUS_REQ=0 and MEM_WAIT=0 immediately.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, a read never answered → BUS_TIMEOUT pulse on the 8th cycle after issue, DATA_RVALID with RDATA=0, MEM_WAIT falls.
